// File: rtl/rx_queue_steer.sv
// rx_queue_steer: store-and-forward receive buffer that steers each packet to an
// RSS queue (indirection table with a fixed destination-port override) and replays
// it on a backpressured AXI-Stream master with the queue index as sideband.
module rx_queue_steer #(
   parameter int unsigned DATA_WIDTH      = 256,
   parameter int unsigned KEEP_WIDTH      = DATA_WIDTH / 8,
   parameter int unsigned QUEUE_WIDTH     = 3,
   parameter int unsigned TABLE_LOG2      = 4,
   parameter int unsigned FIFO_DEPTH_LOG2 = 4,
   parameter int unsigned META_DEPTH_LOG2 = 2,
   parameter logic [15:0] PRIO_PORT       = 16'h0016,
   parameter int unsigned PRIO_QUEUE      = 7
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]      s_axis_tkeep,
   input  logic                       s_axis_tvalid,
   input  logic                       s_axis_tlast,
   input  logic [31:0]                s_hash,
   input  logic [3:0]                 s_hash_type,
   input  logic                       s_hash_valid,
   input  logic [15:0]                s_dest_port,
   input  logic                       tbl_wr_en,
   input  logic [TABLE_LOG2-1:0]      tbl_wr_addr,
   input  logic [QUEUE_WIDTH-1:0]     tbl_wr_data,
   output logic [DATA_WIDTH-1:0]      m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]      m_axis_tkeep,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic                       m_axis_tlast,
   output logic [QUEUE_WIDTH-1:0]     m_axis_tqueue,
   output logic [15:0]                drop_count,
   output logic                       drop_pulse
);

   localparam int unsigned FIFO_DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int unsigned META_DEPTH = 1 << META_DEPTH_LOG2;
   localparam int unsigned TBL_SIZE   = 1 << TABLE_LOG2;
   localparam int unsigned PW         = FIFO_DEPTH_LOG2 + 1;
   localparam int unsigned MPW        = META_DEPTH_LOG2 + 1;
   localparam int unsigned BEAT_W     = DATA_WIDTH + KEEP_WIDTH + 1;

   typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} eg_state_t;

   // storage
   logic [BEAT_W-1:0]      data_mem [FIFO_DEPTH];
   logic [QUEUE_WIDTH-1:0] meta_mem [META_DEPTH];
   logic [QUEUE_WIDTH-1:0] tbl_q    [TBL_SIZE];

   // ingress state
   logic [PW-1:0]          wr_spec_q, wr_spec_d;
   logic [PW-1:0]          wr_cmt_q, wr_cmt_d;
   logic [MPW-1:0]         meta_wr_q, meta_wr_d;
   logic                   dropping_q, dropping_d;
   logic                   resync_q, resync_d;
   logic                   hash_vld_q, hash_vld_d;
   logic [TABLE_LOG2-1:0]  hash_idx_q, hash_idx_d;
   logic                   type_nz_q, type_nz_d;
   logic                   prio_hit_q, prio_hit_d;
   logic [15:0]            drop_cnt_q, drop_cnt_d;
   logic                   drop_pulse_q, drop_pulse_d;
   logic                   mem_we, meta_we, take_hash;
   logic                   fifo_full, meta_full, in_pkt;
   logic                   eff_vld, eff_type_nz, eff_prio;
   logic [TABLE_LOG2-1:0]  eff_idx;
   logic [QUEUE_WIDTH-1:0] q_sel;

   // egress state
   eg_state_t              eg_state_q, eg_state_d;
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [MPW-1:0]         meta_rd_q, meta_rd_d;
   logic [MPW-1:0]         meta_free_q, meta_free_d;
   logic                   last_loaded_q, last_loaded_d;
   logic [DATA_WIDTH-1:0]  m_tdata_q, m_tdata_d;
   logic [KEEP_WIDTH-1:0]  m_tkeep_q, m_tkeep_d;
   logic                   m_tvalid_q, m_tvalid_d;
   logic                   m_tlast_q, m_tlast_d;
   logic [QUEUE_WIDTH-1:0] m_tqueue_q, m_tqueue_d;
   logic [BEAT_W-1:0]      rd_beat;
   logic                   accept;

   logic                   unused_hash_bits;
   assign unused_hash_bits = ^s_hash[31:TABLE_LOG2];

   assign fifo_full = ((wr_spec_q - rd_ptr_q) == PW'(FIFO_DEPTH));
   assign meta_full = ((meta_wr_q - meta_free_q) == MPW'(META_DEPTH));
   assign in_pkt    = (wr_spec_q != wr_cmt_q);

   // hash info seen at commit: a pulse on the tlast beat wins over the latched copy
   assign eff_vld     = s_hash_valid | hash_vld_q;
   assign eff_type_nz = s_hash_valid ? (s_hash_type != 4'd0) : type_nz_q;
   assign eff_prio    = s_hash_valid ? (s_dest_port == PRIO_PORT) : prio_hit_q;
   assign eff_idx     = s_hash_valid ? s_hash[TABLE_LOG2-1:0] : hash_idx_q;

   // queue selection from the pre-write table contents
   always_comb begin
      q_sel = '0;
      if (eff_vld && eff_type_nz) begin
         q_sel = eff_prio ? QUEUE_WIDTH'(PRIO_QUEUE) : tbl_q[eff_idx];
      end
   end

   // ingress: speculative write, commit on tlast, drop/discard handling
   always_comb begin
      wr_spec_d    = wr_spec_q;
      wr_cmt_d     = wr_cmt_q;
      meta_wr_d    = meta_wr_q;
      dropping_d   = dropping_q;
      resync_d     = resync_q;
      hash_vld_d   = hash_vld_q;
      hash_idx_d   = hash_idx_q;
      type_nz_d    = type_nz_q;
      prio_hit_d   = prio_hit_q;
      drop_cnt_d   = drop_cnt_q;
      drop_pulse_d = 1'b0;
      mem_we       = 1'b0;
      meta_we      = 1'b0;
      take_hash    = 1'b0;
      if (resync_q) begin
         // after reset, discard the tail of any packet already in flight
         if (!s_axis_tvalid || s_axis_tlast) begin
            resync_d = 1'b0;
         end
      end else if (s_axis_tvalid && dropping_q) begin
         if (s_axis_tlast) begin
            dropping_d = 1'b0;
         end
      end else if (s_axis_tvalid) begin
         if (fifo_full || (s_axis_tlast && meta_full)) begin
            wr_spec_d    = wr_cmt_q;
            dropping_d   = !s_axis_tlast;
            hash_vld_d   = 1'b0;
            drop_pulse_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
               drop_cnt_d = drop_cnt_q + 16'd1;
            end
         end else begin
            mem_we    = 1'b1;
            wr_spec_d = wr_spec_q + PW'(1);
            if (s_axis_tlast) begin
               wr_cmt_d   = wr_spec_q + PW'(1);
               meta_we    = 1'b1;
               meta_wr_d  = meta_wr_q + MPW'(1);
               hash_vld_d = 1'b0;
            end else begin
               take_hash = s_hash_valid;
            end
         end
      end else begin
         take_hash = s_hash_valid && in_pkt;
      end
      if (take_hash) begin
         hash_vld_d = 1'b1;
         hash_idx_d = s_hash[TABLE_LOG2-1:0];
         type_nz_d  = (s_hash_type != 4'd0);
         prio_hit_d = (s_dest_port == PRIO_PORT);
      end
   end

   assign rd_beat = data_mem[rd_ptr_q[FIFO_DEPTH_LOG2-1:0]];
   assign accept  = m_tvalid_q & m_axis_tready;

   // egress: pop metadata, then stream the committed beats of one packet
   always_comb begin
      eg_state_d    = eg_state_q;
      rd_ptr_d      = rd_ptr_q;
      meta_rd_d     = meta_rd_q;
      meta_free_d   = meta_free_q;
      last_loaded_d = last_loaded_q;
      m_tdata_d     = m_tdata_q;
      m_tkeep_d     = m_tkeep_q;
      m_tvalid_d    = m_tvalid_q;
      m_tlast_d     = m_tlast_q;
      m_tqueue_d    = m_tqueue_q;
      case (eg_state_q)
         ST_IDLE: begin
            if (meta_rd_q != meta_wr_q) begin
               eg_state_d    = ST_SEND;
               m_tqueue_d    = meta_mem[meta_rd_q[META_DEPTH_LOG2-1:0]];
               meta_rd_d     = meta_rd_q + MPW'(1);
               last_loaded_d = 1'b0;
            end
         end
         ST_SEND: begin
            if (accept && m_tlast_q) begin
               eg_state_d  = ST_IDLE;
               m_tvalid_d  = 1'b0;
               meta_free_d = meta_free_q + MPW'(1);
            end else if ((!m_tvalid_q || accept) && !last_loaded_q && (rd_ptr_q != wr_cmt_q)) begin
               m_tdata_d     = rd_beat[DATA_WIDTH-1:0];
               m_tkeep_d     = rd_beat[DATA_WIDTH +: KEEP_WIDTH];
               m_tlast_d     = rd_beat[BEAT_W-1];
               m_tvalid_d    = 1'b1;
               rd_ptr_d      = rd_ptr_q + PW'(1);
               last_loaded_d = rd_beat[BEAT_W-1];
            end else if (accept) begin
               m_tvalid_d = 1'b0;
            end
         end
         default: eg_state_d = ST_IDLE;
      endcase
   end

   // data and metadata storage (contents need no reset; pointers define validity)
   always_ff @(posedge clk) begin
      if (mem_we) begin
         data_mem[wr_spec_q[FIFO_DEPTH_LOG2-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
      end
      if (meta_we) begin
         meta_mem[meta_wr_q[META_DEPTH_LOG2-1:0]] <= q_sel;
      end
   end

   // indirection table, identity-mapped at reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(TBL_SIZE); i++) begin
            tbl_q[i] <= QUEUE_WIDTH'(i);
         end
      end else if (tbl_wr_en) begin
         tbl_q[tbl_wr_addr] <= tbl_wr_data;
      end
   end

   // state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_spec_q     <= '0;
         wr_cmt_q      <= '0;
         meta_wr_q     <= '0;
         dropping_q    <= 1'b0;
         resync_q      <= 1'b1;
         hash_vld_q    <= 1'b0;
         hash_idx_q    <= '0;
         type_nz_q     <= 1'b0;
         prio_hit_q    <= 1'b0;
         drop_cnt_q    <= '0;
         drop_pulse_q  <= 1'b0;
         eg_state_q    <= ST_IDLE;
         rd_ptr_q      <= '0;
         meta_rd_q     <= '0;
         meta_free_q   <= '0;
         last_loaded_q <= 1'b0;
         m_tdata_q     <= '0;
         m_tkeep_q     <= '0;
         m_tvalid_q    <= 1'b0;
         m_tlast_q     <= 1'b0;
         m_tqueue_q    <= '0;
      end else begin
         wr_spec_q     <= wr_spec_d;
         wr_cmt_q      <= wr_cmt_d;
         meta_wr_q     <= meta_wr_d;
         dropping_q    <= dropping_d;
         resync_q      <= resync_d;
         hash_vld_q    <= hash_vld_d;
         hash_idx_q    <= hash_idx_d;
         type_nz_q     <= type_nz_d;
         prio_hit_q    <= prio_hit_d;
         drop_cnt_q    <= drop_cnt_d;
         drop_pulse_q  <= drop_pulse_d;
         eg_state_q    <= eg_state_d;
         rd_ptr_q      <= rd_ptr_d;
         meta_rd_q     <= meta_rd_d;
         meta_free_q   <= meta_free_d;
         last_loaded_q <= last_loaded_d;
         m_tdata_q     <= m_tdata_d;
         m_tkeep_q     <= m_tkeep_d;
         m_tvalid_q    <= m_tvalid_d;
         m_tlast_q     <= m_tlast_d;
         m_tqueue_q    <= m_tqueue_d;
      end
   end

   assign m_axis_tdata  = m_tdata_q;
   assign m_axis_tkeep  = m_tkeep_q;
   assign m_axis_tvalid = m_tvalid_q;
   assign m_axis_tlast  = m_tlast_q;
   assign m_axis_tqueue = m_tqueue_q;
   assign drop_count    = drop_cnt_q;
   assign drop_pulse    = drop_pulse_q;

endmodule

// File: tb/tb_rx_queue_steer.sv
// Testbench for rx_queue_steer: directed scenarios plus randomized traffic,
// checked against a packet-level scoreboard and a table model.
module tb_rx_queue_steer;

   localparam int DW = 256;
   localparam int KW = 32;
   localparam int QW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] s_axis_tdata;
   logic [KW-1:0] s_axis_tkeep;
   logic          s_axis_tvalid;
   logic          s_axis_tlast;
   logic [31:0]   s_hash;
   logic [3:0]    s_hash_type;
   logic          s_hash_valid;
   logic [15:0]   s_dest_port;
   logic          tbl_wr_en;
   logic [3:0]    tbl_wr_addr;
   logic [QW-1:0] tbl_wr_data;
   logic [DW-1:0] m_axis_tdata;
   logic [KW-1:0] m_axis_tkeep;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          m_axis_tlast;
   logic [QW-1:0] m_axis_tqueue;
   logic [15:0]   drop_count;
   logic          drop_pulse;

   always #5 clk = ~clk;

   rx_queue_steer dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
      .s_hash(s_hash), .s_hash_type(s_hash_type), .s_hash_valid(s_hash_valid),
      .s_dest_port(s_dest_port),
      .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast), .m_axis_tqueue(m_axis_tqueue),
      .drop_count(drop_count), .drop_pulse(drop_pulse)
   );

   typedef struct packed {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic          l;
      logic [QW-1:0] q;
   } beat_t;

   beat_t         exp_q[$];
   logic [QW-1:0] tbl_m [16];
   int            vectors = 0;
   int            miscompares = 0;
   int            pkts_sent = 0;
   int            pkts_rx = 0;
   int            drop_pulses = 0;
   int            exp_drops = 0;
   logic [QW-1:0] last_rx_q = '0;
   logic          first_of_pkt = 1'b1;
   logic          rand_ready = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // reference queue choice from the steering rules
   function automatic logic [QW-1:0] exp_queue(input bit hashed, input logic [3:0] typ,
                                               input logic [15:0] port, input logic [31:0] h);
      if (!hashed || typ == 4'd0) return '0;
      if (port == 16'h0016) return QW'(7);
      return tbl_m[h[3:0]];
   endfunction

   // output monitor: scoreboard compare on handshakes, hold check during stalls
   logic  prev_stall = 1'b0;
   beat_t prev_b;
   always begin
      beat_t cur, e;
      @(negedge clk);
      #2;
      if (!rst_n) begin
         prev_stall   = 1'b0;
         first_of_pkt = 1'b1;
      end else begin
         cur = '{d: m_axis_tdata, k: m_axis_tkeep, l: m_axis_tlast, q: m_axis_tqueue};
         if (drop_pulse) drop_pulses++;
         if (prev_stall) begin
            vectors++;
            if (!m_axis_tvalid || cur !== prev_b) begin
               miscompares++;
               $display("FAIL stall_hold: got v=%0b q=%0d l=%0b expected v=1 q=%0d l=%0b",
                        m_axis_tvalid, cur.q, cur.l, prev_b.q, prev_b.l);
            end
         end
         if (m_axis_tvalid && m_axis_tready) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_beat: got q=%0d l=%0b d=%h expected no beat", cur.q, cur.l, cur.d);
            end else begin
               e = exp_q.pop_front();
               if (cur !== e) begin
                  miscompares++;
                  $display("FAIL beat: got d=%h k=%h l=%0b q=%0d expected d=%h k=%h l=%0b q=%0d",
                           cur.d, cur.k, cur.l, cur.q, e.d, e.k, e.l, e.q);
               end
            end
            if (first_of_pkt) last_rx_q = m_axis_tqueue;
            first_of_pkt = m_axis_tlast;
            if (m_axis_tlast) pkts_rx++;
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_b     = cur;
      end
   end

   // random backpressure when enabled
   always @(negedge clk) begin
      if (rand_ready) m_axis_tready = ($urandom_range(9, 0) < 7);
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         s_axis_tvalid = 1'b0;
         s_axis_tlast  = 1'b0;
         s_hash_valid  = 1'b0;
         tbl_wr_en     = 1'b0;
      end
   endtask

   task automatic tbl_write(input logic [3:0] a, input logic [QW-1:0] v);
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      s_hash_valid  = 1'b0;
      tbl_wr_en     = 1'b1;
      tbl_wr_addr   = a;
      tbl_wr_data   = v;
      tbl_m[a]      = v;
   endtask

   // drive one packet; hbeat < 0 means no hash pulse; optional table write on tlast
   task automatic send_pkt(input int len, input int hbeat, input logic [31:0] h,
                           input logic [3:0] typ, input logic [15:0] port, input bit decoy,
                           input bit exp_drop, input bit tw_en, input logic [3:0] tw_a,
                           input logic [QW-1:0] tw_v);
      logic [QW-1:0] q;
      logic [DW-1:0] d;
      q = exp_queue(hbeat >= 0, typ, port, h);
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
         s_axis_tdata  = d;
         s_axis_tkeep  = $urandom;
         s_axis_tvalid = 1'b1;
         s_axis_tlast  = (i == len - 1);
         s_hash_valid  = 1'b0;
         tbl_wr_en     = tw_en && (i == len - 1);
         tbl_wr_addr   = tw_a;
         tbl_wr_data   = tw_v;
         if (i == hbeat) begin
            s_hash_valid = 1'b1;
            s_hash       = h;
            s_hash_type  = typ;
            s_dest_port  = port;
         end else if (decoy && i == 0 && hbeat > 0) begin
            s_hash_valid = 1'b1;
            s_hash       = $urandom;
            s_hash_type  = 4'd1;
            s_dest_port  = 16'h0016;
         end
         if (!exp_drop) exp_q.push_back('{d: d, k: s_axis_tkeep, l: s_axis_tlast, q: q});
      end
      if (tw_en) tbl_m[tw_a] = tw_v;
      if (!exp_drop) pkts_sent++;
   endtask

   task automatic drain(input string name);
      int t = 0;
      while (exp_q.size() != 0 && t < 500) begin
         idle(1);
         t++;
      end
      check(name, 64'(exp_q.size()), 64'd0);
      idle(3);
   endtask

   task automatic simple(input int len, input logic [31:0] h, input logic [3:0] typ,
                         input logic [15:0] port, input bit hashed);
      send_pkt(len, hashed ? 1 : -1, h, typ, port, 1'b0, 1'b0, 1'b0, 4'd0, '0);
   endtask

   initial begin
      int base_pulses;
      int t;
      for (int i = 0; i < 16; i++) tbl_m[i] = QW'(i);
      rst_n = 1'b0;
      s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0;
      s_hash = '0; s_hash_type = '0; s_hash_valid = 1'b0; s_dest_port = '0;
      tbl_wr_en = 1'b0; tbl_wr_addr = '0; tbl_wr_data = '0; m_axis_tready = 1'b1;

      // reset held with input valid high
      repeat (3) @(negedge clk);
      #2;
      check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_tdata_or", 64'(|m_axis_tdata), 64'd0);
      check("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
      check("rst_tlast", 64'(m_axis_tlast), 64'd0);
      check("rst_tqueue", 64'(m_axis_tqueue), 64'd0);
      check("rst_drop_count", 64'(drop_count), 64'd0);
      check("rst_drop_pulse", 64'(drop_pulse), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      s_axis_tvalid = 1'b0;
      idle(2);

      // identity table, latency from input tlast
      simple(4, 32'h00000005, 4'd1, 16'h0015, 1'b1);
      idle(2);
      #2 check("lat_e1_tvalid", 64'(m_axis_tvalid), 64'd0);
      idle(1);
      #2 check("lat_e2_tvalid", 64'(m_axis_tvalid), 64'd1);
      drain("drain_t2");
      check("q_identity", 64'(last_rx_q), 64'd5);

      // priority port, unhashed type, missing hash
      simple(4, 32'h00000005, 4'd1, 16'h0016, 1'b1);
      drain("drain_prio");
      check("q_prio", 64'(last_rx_q), 64'd7);
      simple(4, 32'h00000005, 4'd0, 16'h0016, 1'b1);
      drain("drain_type0");
      check("q_type0", 64'(last_rx_q), 64'd0);
      simple(4, 32'h00000005, 4'd1, 16'h0015, 1'b0);
      drain("drain_nohash");
      check("q_nohash", 64'(last_rx_q), 64'd0);

      // table writes, including one coincident with commit
      tbl_write(4'd5, 3'd2);
      idle(1);
      simple(3, 32'hABCD0015, 4'd1, 16'h0015, 1'b1);
      drain("drain_tbl");
      check("q_tbl_write", 64'(last_rx_q), 64'd2);
      send_pkt(3, 2, 32'hABCD0015, 4'd1, 16'h0015, 1'b0, 1'b0, 1'b1, 4'd5, 3'd3);
      idle(1);
      drain("drain_tbl_same");
      check("q_tbl_same_cycle", 64'(last_rx_q), 64'd2);
      simple(2, 32'h12340005, 4'd1, 16'h0015, 1'b1);
      drain("drain_tbl_after");
      check("q_tbl_after", 64'(last_rx_q), 64'd3);

      // long stall with two packets buffered
      m_axis_tready = 1'b0;
      simple(3, 32'h00000001, 4'd2, 16'h0080, 1'b1);
      idle(1);
      simple(4, 32'h00000016, 4'd2, 16'h0080, 1'b1);
      idle(12);
      m_axis_tready = 1'b1;
      drain("drain_stall");
      check("stall_drop_count", 64'(drop_count), 64'(exp_drops));

      // metadata FIFO full: fifth outstanding packet dropped
      base_pulses = drop_pulses;
      m_axis_tready = 1'b0;
      for (int p = 0; p < 5; p++)
         send_pkt(2, 0, 32'(p), 4'd1, 16'h0015, 1'b0, p == 4, 1'b0, 4'd0, '0);
      exp_drops++;
      idle(4);
      check("meta_full_drop_count", 64'(drop_count), 64'(exp_drops));
      m_axis_tready = 1'b1;
      drain("drain_meta_full");
      check("meta_full_pulses", 64'(drop_pulses - base_pulses), 64'd1);

      // oversize packet dropped, next packet intact
      base_pulses = drop_pulses;
      send_pkt(20, 3, 32'h00000009, 4'd1, 16'h0015, 1'b0, 1'b1, 1'b0, 4'd0, '0);
      exp_drops++;
      simple(2, 32'h00000006, 4'd1, 16'h0015, 1'b1);
      drain("drain_oversize");
      check("oversize_drop_count", 64'(drop_count), 64'(exp_drops));
      check("oversize_pulses", 64'(drop_pulses - base_pulses), 64'd1);
      check("q_after_oversize", 64'(last_rx_q), 64'd6);

      // randomized traffic with bounded occupancy
      rand_ready = 1'b1;
      for (int n = 0; n < 60; n++) begin
         int len, hb;
         logic [3:0] typ;
         logic [15:0] port;
         t = 0;
         while ((pkts_sent - pkts_rx) > 2 && t < 1000) begin
            idle(1);
            t++;
         end
         if (t >= 1000) check("rand_backlog_timeout", 64'(pkts_sent - pkts_rx), 64'd2);
         if ($urandom_range(3, 0) == 0) tbl_write(4'($urandom), QW'($urandom));
         idle($urandom_range(2, 0));
         len  = $urandom_range(5, 1);
         hb   = ($urandom_range(4, 0) == 0) ? -1 : $urandom_range(len - 1, 0);
         typ  = ($urandom_range(3, 0) == 0) ? 4'd0 : 4'($urandom_range(15, 1));
         port = ($urandom_range(3, 0) == 0) ? 16'h0016 : 16'($urandom);
         send_pkt(len, hb, $urandom, typ, port, $urandom_range(4, 0) == 0, 1'b0, 1'b0, 4'd0, '0);
      end
      idle(1);
      t = 0;
      while (exp_q.size() != 0 && t < 2000) begin
         idle(1);
         t++;
      end
      rand_ready = 1'b0;
      m_axis_tready = 1'b1;
      drain("drain_random");
      check("random_drop_count", 64'(drop_count), 64'(exp_drops));

      // reset in the middle of a packet; its tail continues after release
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 3) rst_n = 1'b0;
         if (i == 5) rst_n = 1'b1;
         s_axis_tdata  = {8{$urandom}};
         s_axis_tkeep  = $urandom;
         s_axis_tvalid = 1'b1;
         s_axis_tlast  = (i == 7);
         s_hash_valid  = 1'b0;
      end
      for (int i = 0; i < 16; i++) tbl_m[i] = QW'(i);
      exp_drops = 0;
      idle(3);
      #2 check("post_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      simple(3, 32'h00000004, 4'd1, 16'h0015, 1'b1);
      drain("drain_post_rst");
      check("q_post_rst", 64'(last_rx_q), 64'd4);
      check("post_rst_drop_count", 64'(drop_count), 64'd0);
      idle(5);
      check("final_empty", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
